// File: rtl/bn_sign_pack.sv
// Batch-norm threshold + sign binarization of a conv result stream, packed into
// PACK_W-bit words behind a FWFT FIFO. Optional BNN_GAMMA_NEG_EN adds thr_neg (din <= thr).
module bn_sign_pack #(
  parameter int DATA_W     = 32,
  parameter int PACK_W     = 16,
  parameter int LEN_S0     = 144,
  parameter int LEN_S1     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              state,
  input  logic              thr_en,
  input  logic [DATA_W-1:0] thr,
`ifdef BNN_GAMMA_NEG_EN
  input  logic              thr_neg,
`endif
  input  logic [DATA_W-1:0] din,
  input  logic              ivalid,
  input  logic              idone,
  output logic [PACK_W-1:0] dout,
  output logic              ovalid,
  input  logic              oready,
  output logic              olast,
  output logic              done,
  output logic              ovf,
  output logic              len_err,
  output logic [1:0]        dbg_state
);

  localparam int BC_W  = $clog2(PACK_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BC_W-1:0]  BC_MAX = BC_W'(PACK_W - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [1:0]        fsm_q, fsm_d;
  logic              layer_q, layer_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic              ovf_q, ovf_d;
  logic              len_err_q, len_err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [PACK_W:0]   mem_q [FIFO_DEPTH];
`ifdef BNN_GAMMA_NEG_EN
  logic              thr_neg_q, thr_neg_d;
`endif

  logic              empty, full, pop, din_bit;
  logic              push, push_last, wr_en, tag_last, tag_en;
  logic [PACK_W-1:0] push_word, word_w;
  logic [PACK_W:0]   head;
  logic [PTR_W:0]    count_after;
  logic [CNT_W-1:0]  exp_len;

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign pop         = !empty && oready;
  assign head        = mem_q[rd_ptr_q];
  assign count_after = count_q - (PTR_W+1)'(pop);
  assign exp_len     = layer_q ? CNT_W'(LEN_S1) : CNT_W'(LEN_S0);

  assign ovalid    = !empty;
  assign dout      = empty ? '0 : head[PACK_W-1:0];
  assign olast     = !empty && head[PACK_W];
  assign done      = (fsm_q == S_DONE);
  assign ovf       = ovf_q;
  assign len_err   = len_err_q;
  assign dbg_state = fsm_q;

`ifdef BNN_GAMMA_NEG_EN
  assign din_bit = thr_neg_q ? ($signed(din) <= $signed(thr_q))
                             : ($signed(din) >= $signed(thr_q));
`else
  assign din_bit = ($signed(din) >= $signed(thr_q));
`endif

  assign word_w = pack_q | (PACK_W'(din_bit) << bit_cnt_q);

  always_comb begin
    fsm_d     = fsm_q;
    layer_d   = layer_q;
    thr_d     = thr_q;
    pack_d    = pack_q;
    bit_cnt_d = bit_cnt_q;
    res_cnt_d = res_cnt_q;
    ovf_d     = ovf_q;
    len_err_d = len_err_q;
    push      = 1'b0;
    push_word = pack_q;
    push_last = 1'b0;
    tag_last  = 1'b0;
`ifdef BNN_GAMMA_NEG_EN
    thr_neg_d = thr_neg_q;
    if (thr_en) thr_neg_d = thr_neg;
`endif
    if (thr_en) thr_d = thr;

    if (start) begin
      fsm_d     = S_RUN;
      layer_d   = state;
      pack_d    = '0;
      bit_cnt_d = '0;
      res_cnt_d = '0;
      ovf_d     = 1'b0;
      len_err_d = 1'b0;
    end else begin
      case (fsm_q)
        S_RUN: begin
          if (ivalid) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
            if (bit_cnt_q == BC_MAX) begin
              push      = 1'b1;
              push_word = word_w;
              push_last = idone;
              pack_d    = '0;
              bit_cnt_d = '0;
            end else begin
              pack_d    = word_w;
              bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
          end
          if (idone) begin
            fsm_d = S_DRAIN;
            if (res_cnt_q + CNT_W'(ivalid) != exp_len) len_err_d = 1'b1;
            if (!(ivalid && bit_cnt_q == BC_MAX)) begin
              if (ivalid || bit_cnt_q != '0) begin
                push      = 1'b1;
                push_word = ivalid ? word_w : pack_q;
                push_last = 1'b1;
                pack_d    = '0;
                bit_cnt_d = '0;
              end else begin
                // Boundary word was pushed on an earlier result: retag it in the FIFO.
                tag_last = 1'b1;
              end
            end
          end
        end
        S_DRAIN: if (pop && head[PACK_W]) fsm_d = S_DONE;
        S_DONE:  fsm_d = S_IDLE;
        default: fsm_d = fsm_q;
      endcase
    end

    // Nothing left to tag (empty map or word already consumed): finish directly.
    if (tag_last && count_after == '0) fsm_d = S_DONE;
    tag_en = tag_last && (count_after != '0);

    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push && full && !pop) ovf_d = 1'b1;
    if (start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      layer_q   <= 1'b0;
      thr_q     <= '0;
      pack_q    <= '0;
      bit_cnt_q <= '0;
      res_cnt_q <= '0;
      ovf_q     <= 1'b0;
      len_err_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef BNN_GAMMA_NEG_EN
      thr_neg_q <= 1'b0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      layer_q   <= layer_d;
      thr_q     <= thr_d;
      pack_q    <= pack_d;
      bit_cnt_q <= bit_cnt_d;
      res_cnt_q <= res_cnt_d;
      ovf_q     <= ovf_d;
      len_err_q <= len_err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef BNN_GAMMA_NEG_EN
      thr_neg_q <= thr_neg_d;
`endif
    end
  end

  // Storage is not reset; dout/olast are gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en)  mem_q[wr_ptr_q] <= {push_last, push_word};
    if (tag_en) mem_q[wr_ptr_q - PTR_W'(1)][PACK_W] <= 1'b1;
  end

endmodule

// File: tb/tb_bn_sign_pack.sv
// Directed bench for bn_sign_pack: hand-computed packed words checked through an
// expected-word queue, plus status/reset checks.
module tb_bn_sign_pack;

  localparam int DATA_W = 32;
  localparam int PACK_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              state = 1'b0;
  logic              thr_en = 1'b0;
  logic [DATA_W-1:0] thr = '0;
  logic [DATA_W-1:0] din = '0;
  logic              ivalid = 1'b0;
  logic              idone = 1'b0;
  logic [PACK_W-1:0] dout;
  logic              ovalid;
  logic              oready = 1'b0;
  logic              olast;
  logic              done;
  logic              ovf;
  logic              len_err;
  logic [1:0]        dbg_state;

  bn_sign_pack dut (
    .clk(clk), .rst(rst), .start(start), .state(state),
    .thr_en(thr_en), .thr(thr), .din(din), .ivalid(ivalid), .idone(idone),
    .dout(dout), .ovalid(ovalid), .oready(oready), .olast(olast),
    .done(done), .ovf(ovf), .len_err(len_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;
  logic [PACK_W:0] exp_q[$];
  logic [PACK_W:0] exp_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (ovalid && oready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(ovalid), 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", 32'({olast, dout}), 32'(exp_w));
          if (olast) last_pop_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start(input logic layer);
    state = layer;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_thr(input logic [DATA_W-1:0] t);
    thr    = t;
    thr_en = 1'b1;
    tick();
    thr_en = 1'b0;
  endtask

  task automatic drive_res(input logic [DATA_W-1:0] d, input logic last);
    din    = d;
    ivalid = 1'b1;
    idone  = last;
    tick();
    ivalid = 1'b0;
    idone  = 1'b0;
  endtask

  // Alternating +5/-5 starting with +5; idone optional on the final result.
  task automatic send_alt(input int n, input logic with_done);
    for (int i = 0; i < n; i++)
      drive_res((i % 2 == 0) ? 32'd5 : 32'hFFFF_FFFB, with_done && (i == n - 1));
  endtask

  task automatic expect_words(input int n, input logic [PACK_W-1:0] w, input logic last_on_final);
    for (int i = 0; i < n; i++)
      exp_q.push_back({last_on_final && (i == n - 1), w});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ovalid", 32'(ovalid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_olast", 32'(olast), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // Full 12x12 map, alternating signs
    oready = 1'b1;
    load_thr(32'd0);
    expect_words(9, 16'h5555, 1'b1);
    done_cnt = 0;
    pulse_start(1'b0);
    send_alt(144, 1'b1);
    idle(6);
    check("s1_words_left", 32'(exp_q.size()), 32'd0);
    check("s1_done_cnt", 32'(done_cnt), 32'd1);
    check("s1_done_lat", 32'(done_cyc - last_pop_cyc), 32'd1);
    check("s1_ovf", 32'(ovf), 32'd0);
    check("s1_len_err", 32'(len_err), 32'd0);
    check("s1_idle", 32'(dbg_state), 32'd0);

    // 4x4 map, thr=10: bits 1,0,1,0 then twelve 1s
    load_thr(32'd10);
    expect_words(1, 16'hFFF5, 1'b1);
    done_cnt = 0;
    pulse_start(1'b1);
    drive_res(32'd10, 1'b0);
    drive_res(32'd9, 1'b0);
    drive_res(32'd11, 1'b0);
    drive_res(32'hFFFF_FFFD, 1'b0);
    for (int i = 0; i < 11; i++) drive_res(32'd100, 1'b0);
    drive_res(32'd100, 1'b1);
    check("s2_lat_ovalid", 32'(ovalid), 32'd1);
    check("s2_lat_dout", 32'(dout), 32'hFFF5);
    idle(4);
    check("s2_words_left", 32'(exp_q.size()), 32'd0);
    check("s2_done_cnt", 32'(done_cnt), 32'd1);
    check("s2_len_err", 32'(len_err), 32'd0);

    // Signed boundary, thr=-1: -1 ->1, -2 ->0, max ->1, min ->0
    load_thr(32'hFFFF_FFFF);
    expect_words(1, 16'h0005, 1'b1);
    done_cnt = 0;
    pulse_start(1'b1);
    drive_res(32'hFFFF_FFFF, 1'b0);
    drive_res(32'hFFFF_FFFE, 1'b0);
    drive_res(32'h7FFF_FFFF, 1'b0);
    drive_res(32'h8000_0000, 1'b0);
    for (int i = 0; i < 12; i++) drive_res(32'hFFFF_FFFB, i == 11);
    idle(4);
    check("s3_words_left", 32'(exp_q.size()), 32'd0);
    check("s3_done_cnt", 32'(done_cnt), 32'd1);

    // Consumer stalled for a whole map: 8 held, 9th dropped
    load_thr(32'd0);
    oready = 1'b0;
    done_cnt = 0;
    pulse_start(1'b0);
    send_alt(144, 1'b1);
    idle(2);
    check("s4_ovf", 32'(ovf), 32'd1);
    check("s4_ovalid", 32'(ovalid), 32'd1);
    check("s4_len_err", 32'(len_err), 32'd0);
    check("s4_drain", 32'(dbg_state), 32'd2);
    expect_words(8, 16'h5555, 1'b0);
    oready = 1'b1;
    idle(12);
    check("s4_words_left", 32'(exp_q.size()), 32'd0);
    check("s4_no_done", 32'(done_cnt), 32'd0);
    check("s4_empty", 32'(ovalid), 32'd0);
    check("s4_stuck", 32'(dbg_state), 32'd2);

    // Short map: 10 results on a 16-result layer
    expect_words(1, 16'h03FF, 1'b1);
    done_cnt = 0;
    pulse_start(1'b1);
    check("s5_ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 10; i++) drive_res(32'd1, i == 9);
    check("s5_len_err", 32'(len_err), 32'd1);
    idle(4);
    check("s5_words_left", 32'(exp_q.size()), 32'd0);
    check("s5_done_cnt", 32'(done_cnt), 32'd1);
    pulse_start(1'b1);
    check("s5_len_err_clr", 32'(len_err), 32'd0);

    // Asynchronous reset in the middle of a map
    oready = 1'b0;
    pulse_start(1'b0);
    send_alt(70, 1'b0);
    check("s6_pre_ovalid", 32'(ovalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_ovalid", 32'(ovalid), 32'd0);
    check("s6_rst_dout", 32'(dout), 32'd0);
    check("s6_rst_olast", 32'(olast), 32'd0);
    check("s6_rst_state", 32'(dbg_state), 32'd0);
    tick();
    rst = 1'b0;
    oready = 1'b1;
    expect_words(9, 16'h5555, 1'b1);
    done_cnt = 0;
    pulse_start(1'b0);
    send_alt(144, 1'b1);
    idle(6);
    check("s6_words_left", 32'(exp_q.size()), 32'd0);
    check("s6_done_cnt", 32'(done_cnt), 32'd1);
    check("s6_ovf", 32'(ovf), 32'd0);
    check("s6_len_err", 32'(len_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
